// File: rtl/sysid_probe.sv
// Avalon-MM read master that fetches the system-ID word and build timestamp
// from the sysid slave and flags whether each matches its expected value.
module sysid_probe #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1300963752,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic        sysid_waitrequest,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAT_LAST   = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, REQ, LAT, DONE} state_t;

    state_t      state, state_nxt;
    logic        addr_sel;
    logic        pending_start;
    logic        id_got, ts_got;
    logic [15:0] stall_cnt;
    logic [2:0]  lat_cnt;
    logic        go, accept, stall_to, capture;

    // Read strobe and address come straight from state so reset drops them at once.
    assign sysid_read    = (state == REQ);
    assign sysid_address = addr_sel;
    assign busy          = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        accept    = 1'b0;
        stall_to  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: if (pending_start || start) begin
                go        = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                if (!sysid_waitrequest) begin
                    accept = 1'b1;
                    if (READ_LATENCY == 0) begin
                        capture   = 1'b1;
                        state_nxt = addr_sel ? DONE : REQ;
                    end else begin
                        state_nxt = LAT;
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    stall_to  = 1'b1;
                    state_nxt = DONE;
                end
            end
            LAT: if (lat_cnt == LAT_LAST) begin
                capture   = 1'b1;
                state_nxt = addr_sel ? DONE : REQ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_start <= AUTO_START;
            addr_sel      <= 1'b0;
            id_got        <= 1'b0;
            ts_got        <= 1'b0;
            stall_cnt     <= '0;
            lat_cnt       <= '0;
            done          <= 1'b0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            timeout       <= 1'b0;
            id_value      <= '0;
            ts_value      <= '0;
        end else begin
            if (go) begin
                pending_start <= 1'b0;
                addr_sel      <= 1'b0;
                id_got        <= 1'b0;
                ts_got        <= 1'b0;
                stall_cnt     <= '0;
                lat_cnt       <= '0;
                done          <= 1'b0;
                id_ok         <= 1'b0;
                ts_ok         <= 1'b0;
                timeout       <= 1'b0;
                id_value      <= '0;
                ts_value      <= '0;
            end
            if (state == REQ) begin
                if (accept) begin
                    stall_cnt <= '0;
                    lat_cnt   <= '0;
                end else if (stall_to) begin
                    timeout <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + 16'd1;
                end
            end
            if (state == LAT) lat_cnt <= lat_cnt + 3'd1;
            if (capture) begin
                if (!addr_sel) begin
                    id_value <= sysid_readdata;
                    id_got   <= 1'b1;
                    addr_sel <= 1'b1;
                end else begin
                    ts_value <= sysid_readdata;
                    ts_got   <= 1'b1;
                end
            end
            // A word never read keeps its ok flag low even if 0 would match.
            if (state == DONE) begin
                done  <= 1'b1;
                id_ok <= id_got && (id_value == EXPECTED_ID);
                ts_ok <= ts_got && (ts_value == EXPECTED_TS);
            end
        end
    end

endmodule
